// File: rtl/rvx10_pkg.sv
// Shared RVX10 pipeline types: hazard FSM states and forwarding-select encodings.
package rvx10_pkg;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    LU_STALL  = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/rvx10_fwd_sel.sv
// One EX-stage operand forwarding select; MEM result beats WB result, x0 never forwards.
module rvx10_fwd_sel
  import rvx10_pkg::*;
#(
  parameter int NREG_BITS = 5
) (
  input  logic [NREG_BITS-1:0] rs_e,
  input  logic [NREG_BITS-1:0] rd_m,
  input  logic                 reg_write_m,
  input  logic [NREG_BITS-1:0] rd_w,
  input  logic                 reg_write_w,
  output logic [1:0]           fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/rvx10_hazard_unit.sv
// RVX10 hazard controller: EX forwarding, one-cycle load-use stall, redirect flushes.
// Performance counters are live only when RVX10_HAZARD_PERF_EN is defined.
//
// state     | meaning
// RST_FLUSH | first cycle(s) after reset: bubble D and E
// RUN       | normal issue; may raise a load-use stall
// LU_STALL  | bubble already in EX; release the stall
module rvx10_hazard_unit
  import rvx10_pkg::*;
#(
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREG_BITS-1:0] rs1_d,
  input  logic [NREG_BITS-1:0] rs2_d,
  input  logic [NREG_BITS-1:0] rs1_e,
  input  logic [NREG_BITS-1:0] rs2_e,
  input  logic [NREG_BITS-1:0] rd_e,
  input  logic                 load_e,
  input  logic                 pc_src_e,
  input  logic [NREG_BITS-1:0] rd_m,
  input  logic                 reg_write_m,
  input  logic [NREG_BITS-1:0] rd_w,
  input  logic                 reg_write_w,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [1:0]           fwd_a_e,
  output logic [1:0]           fwd_b_e,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_cycles
);

  hazard_state_t state;
  logic          lu;

  rvx10_fwd_sel #(.NREG_BITS(NREG_BITS)) u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_a_e)
  );

  rvx10_fwd_sel #(.NREG_BITS(NREG_BITS)) u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_b_e)
  );

  assign lu = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_FLUSH;
    end else begin
      case (state)
        RST_FLUSH: state <= RUN;
        RUN:       if (lu && !pc_src_e) state <= LU_STALL;
        LU_STALL:  state <= RUN;
        default:   state <= RST_FLUSH;
      endcase
    end
  end

  // A taken redirect squashes the load's consumer, so it overrides the stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b1;
    flush_e = 1'b1;
    case (state)
      RUN: begin
        stall_f = lu && !pc_src_e;
        stall_d = lu && !pc_src_e;
        flush_d = pc_src_e;
        flush_e = pc_src_e || lu;
      end
      LU_STALL: begin
        flush_d = pc_src_e;
        flush_e = pc_src_e;
      end
      default: ;
    endcase
  end

`ifdef RVX10_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state != RST_FLUSH) begin
      if (stall_d)  stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_src_e) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_rvx10_hazard_unit.sv
// Scoreboard bench for rvx10_hazard_unit: directed vectors push expectations, a monitor checks them.
module tb_rvx10_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        load_e, pc_src_e, reg_write_m, reg_write_w;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [31:0] stall_cycles, flush_cycles;

  typedef struct {
    string       name;
    logic        stall;
    logic        fd;
    logic        fe;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_fc = 0;
  bit          done = 0;

  always #5 clk = ~clk;

  rvx10_hazard_unit #(.NREG_BITS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .load_e       (load_e),
    .pc_src_e     (pc_src_e),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  task automatic chk(input string name, input string sig, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0h expected=%0h", name, sig, act, exp);
    end
  endtask

  // Monitor: each cycle's outputs are checked mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "stall_f", {31'd0, stall_f}, {31'd0, e.stall});
        chk(e.name, "stall_d", {31'd0, stall_d}, {31'd0, e.stall});
        chk(e.name, "flush_d", {31'd0, flush_d}, {31'd0, e.fd});
        chk(e.name, "flush_e", {31'd0, flush_e}, {31'd0, e.fe});
        chk(e.name, "fwd_a_e", {30'd0, fwd_a_e}, {30'd0, e.fa});
        chk(e.name, "fwd_b_e", {30'd0, fwd_b_e}, {30'd0, e.fb});
        chk(e.name, "stall_cycles", stall_cycles, e.sc);
        chk(e.name, "flush_cycles", flush_cycles, e.fc);
      end
    end
  end

  // rf marks a cycle the hazard FSM spends in RST_FLUSH (no counting there).
  task automatic apply(input string name, input logic rst,
                       input logic [4:0] i_rs1_d, input logic [4:0] i_rs2_d,
                       input logic [4:0] i_rs1_e, input logic [4:0] i_rs2_e,
                       input logic [4:0] i_rd_e, input logic i_load, input logic i_pc_src,
                       input logic [4:0] i_rd_m, input logic i_rwm,
                       input logic [4:0] i_rd_w, input logic i_rww,
                       input logic x_stall, input logic x_fd, input logic x_fe,
                       input logic [1:0] x_fa, input logic [1:0] x_fb, input logic rf);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; rs1_d = i_rs1_d; rs2_d = i_rs2_d; rs1_e = i_rs1_e; rs2_e = i_rs2_e;
    rd_e = i_rd_e; load_e = i_load; pc_src_e = i_pc_src;
    rd_m = i_rd_m; reg_write_m = i_rwm; rd_w = i_rd_w; reg_write_w = i_rww;
    if (!rst) begin
      exp_sc = 0;
      exp_fc = 0;
    end
    e.name = name; e.stall = x_stall; e.fd = x_fd; e.fe = x_fe;
    e.fa = x_fa; e.fb = x_fb;
`ifdef RVX10_HAZARD_PERF_EN
    e.sc = exp_sc; e.fc = exp_fc;
`else
    e.sc = 0; e.fc = 0;
`endif
    sb.push_back(e);
    if (rst && !rf) begin
      exp_sc = exp_sc + {31'd0, x_stall};
      exp_fc = exp_fc + {31'd0, i_pc_src};
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {load_e, pc_src_e, reg_write_m, reg_write_w} = '0;

    //     name            rst rs1d rs2d rs1e rs2e rde ld pc rdm wm rdw ww  st fd fe fa     fb     rf
    for (int i = 0; i < 3; i++)
      apply("rst_hold",     0,  0,   7,   5,   0,   7,  1, 1, 5,  1, 0,  0,  0, 1, 1, 2'b10, 2'b00, 1);
    apply("rst_release",    1,  0,   7,   5,   0,   7,  1, 1, 5,  1, 0,  0,  0, 1, 1, 2'b10, 2'b00, 1);
    apply("run_idle",       1,  0,   0,   0,   0,   0,  0, 0, 0,  0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
    apply("fwd_mem_prio",   1,  0,   0,   5,   5,   0,  0, 0, 5,  1, 5,  1,  0, 0, 0, 2'b10, 2'b10, 0);
    apply("fwd_wb",         1,  0,   0,   5,   5,   0,  0, 0, 5,  0, 5,  1,  0, 0, 0, 2'b01, 2'b01, 0);
    apply("fwd_rs_x0",      1,  0,   0,   0,   5,   0,  0, 0, 5,  0, 5,  1,  0, 0, 0, 2'b00, 2'b01, 0);
    apply("fwd_rdm_x0",     1,  0,   0,   3,   3,   0,  0, 0, 0,  1, 3,  1,  0, 0, 0, 2'b01, 2'b01, 0);
    apply("fwd_split",      1,  0,   0,   4,   6,   0,  0, 0, 4,  1, 6,  1,  0, 0, 0, 2'b10, 2'b01, 0);
    apply("lu_stall",       1,  0,   7,   0,   0,   7,  1, 0, 0,  0, 0,  0,  1, 0, 1, 2'b00, 2'b00, 0);
    apply("lu_held",        1,  0,   7,   0,   0,   7,  1, 0, 0,  0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
    apply("lu_consumer",    1,  0,   0,   0,   7,   0,  0, 0, 0,  0, 7,  1,  0, 0, 0, 2'b00, 2'b01, 0);
    apply("br_vs_lu",       1,  9,   0,   0,   0,   9,  1, 1, 0,  0, 0,  0,  0, 1, 1, 2'b00, 2'b00, 0);
    apply("lu_after_br",    1,  9,   0,   0,   0,   9,  1, 0, 0,  0, 0,  0,  1, 0, 1, 2'b00, 2'b00, 0);
    apply("br_in_lustall",  1,  9,   0,   0,   0,   9,  1, 1, 0,  0, 0,  0,  0, 1, 1, 2'b00, 2'b00, 0);
    apply("rd_x0",          1,  0,   0,   0,   0,   0,  1, 0, 0,  0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
`ifdef RVX10_HAZARD_PERF_EN
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_sc = 32'hFFFF_FFFF;
`endif
    apply("lu_wrap",        1,  0,   3,   0,   0,   3,  1, 0, 0,  0, 0,  0,  1, 0, 1, 2'b00, 2'b00, 0);
    apply("rst_mid_stall",  0,  0,   3,   0,   0,   3,  1, 0, 0,  0, 0,  0,  0, 1, 1, 2'b00, 2'b00, 1);
    apply("rst_flush_once", 1,  0,   3,   0,   0,   3,  1, 0, 0,  0, 0,  0,  0, 1, 1, 2'b00, 2'b00, 1);
    apply("run_after_rst",  1,  0,   3,   0,   0,   3,  1, 0, 0,  0, 0,  0,  1, 0, 1, 2'b00, 2'b00, 0);
    apply("idle_lustall",   1,  0,   0,   0,   0,   0,  0, 0, 0,  0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
    apply("idle_run",       1,  0,   0,   0,   0,   0,  0, 1, 0,  0, 0,  0,  0, 1, 1, 2'b00, 2'b00, 0);
    apply("final_counts",   1,  0,   0,   0,   0,   0,  0, 0, 0,  0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
    done = 1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    total++;
    if (!done || sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d pending expected=0 pending (done=%0d)", sb.size(), done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
